regfile_write_arbiter: RTL

//  Shares the single register-file write port (RegWrite/rd/WriteData) between two writeback sources.

---
 rtl/regfile_write_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter: one holding buffer per source feeding the single register-file write port.
// Define REGFILE_ARB_RR_EN for round-robin arbitration; the default is fixed priority (req0 > req1).
module regfile_write_arbiter #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 5,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [XLEN-1:0]   req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [XLEN-1:0]   req1_data,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] rd,
    output logic [XLEN-1:0]   WriteData,
    output logic              busy,
    output logic [DROP_W-1:0] drop_count
);

    logic              full0, full1;
    logic [ADDR_W-1:0] buf0_rd, buf1_rd;
    logic [XLEN-1:0]   buf0_data, buf1_data;
    logic              grant0, grant1;
    logic              accept0, accept1;
    logic              any_grant;
    logic [ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic              sel_is_x0;

`ifdef REGFILE_ARB_RR_EN
    // rr_ptr names the preferred source; a lone full buffer wins regardless.
    logic rr_ptr;

    always_comb begin
        grant0 = full0 & (~full1 | ~rr_ptr);
        grant1 = full1 & (~full0 | rr_ptr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (grant0) begin
            rr_ptr <= 1'b1;
        end else if (grant1) begin
            rr_ptr <= 1'b0;
        end
    end
`else
    always_comb begin
        grant0 = full0;
        grant1 = full1 & ~full0;
    end
`endif

    // Handshake: a request transfers on the rising edge where valid && ready are both high;
    // ready depends only on registered state, so it never combinationally follows valid.
    assign req0_ready = ~full0 | grant0;
    assign req1_ready = ~full1 | grant1;
    assign accept0    = req0_valid & req0_ready;
    assign accept1    = req1_valid & req1_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full0     <= 1'b0;
            buf0_rd   <= '0;
            buf0_data <= '0;
        end else if (accept0) begin
            full0     <= 1'b1;
            buf0_rd   <= req0_rd;
            buf0_data <= req0_data;
        end else if (grant0) begin
            full0     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full1     <= 1'b0;
            buf1_rd   <= '0;
            buf1_data <= '0;
        end else if (accept1) begin
            full1     <= 1'b1;
            buf1_rd   <= req1_rd;
            buf1_data <= req1_data;
        end else if (grant1) begin
            full1     <= 1'b0;
        end
    end

    assign any_grant = grant0 | grant1;
    assign sel_rd    = grant0 ? buf0_rd   : buf1_rd;
    assign sel_data  = grant0 ? buf0_data : buf1_data;
    assign sel_is_x0 = (sel_rd == '0);

    // x0 entries are consumed silently; rd/WriteData keep the last real write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite   <= 1'b0;
            rd         <= '0;
            WriteData  <= '0;
            drop_count <= '0;
        end else begin
            RegWrite <= any_grant & ~sel_is_x0;
            if (any_grant && !sel_is_x0) begin
                rd        <= sel_rd;
                WriteData <= sel_data;
            end
            if (any_grant && sel_is_x0 && (drop_count != '1)) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

    assign busy = full0 | full1 | RegWrite;

endmodule
